tick_timekeeper: RTL and testbench

- Consumer end of the 500 Hz divided clock. Samples the divider output as data in the system clk domain. Does not use it as a clock.
- Synchronizes it, detects rising edges, and prescales the edges to 1 Hz. Keeps an HH:MM:SS time-of-day count for the hood display and timers.
- Flags a stalled divider: no edge within a bounded window.

---
 rtl/tick_timekeeper.sv | 143 ++++++++++++++
 tb/tb_tick_timekeeper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timekeeper.sv
// tick_timekeeper: samples the 500 Hz divider output as data in the clk domain,
// turns each rising edge into a one-cycle tick, prescales ticks down to seconds
// and keeps an HH:MM:SS time-of-day count. A watchdog flags a stalled divider
// when no tick has been seen for STALL_CYCLES clocks.
module tick_timekeeper #(
  parameter int SYNC_STAGES   = 2,
  parameter int TICKS_PER_SEC = 500,
  parameter int STALL_CYCLES  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       tick_pulse,
  output logic       sec_pulse,
  output logic       load_err,
  output logic       clk_fault
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_tickPulse;
  logic [PW-1:0]          r_presc;
  logic [SW-1:0]          r_stall;
  logic [4:0]             r_hh;
  logic [5:0]             r_mm;
  logic [5:0]             r_ss;
  logic                   r_secPulse;
  logic                   r_loadErr;

  logic                   w_syncOut;
  logic                   w_loadValid;
  logic                   w_advance;
  logic                   w_wrap;
  logic [4:0]             w_hhNext;
  logic [5:0]             w_mmNext;
  logic [5:0]             w_ssNext;

  assign w_syncOut   = r_sync[SYNC_STAGES-1];
  assign w_loadValid = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
  assign w_advance   = r_tickPulse && run;
  assign w_wrap      = w_advance && (r_presc == PRESC_LAST);

  // Shift the asynchronous tick_in through the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
    end
  end

  // Remember the previous synchronized level and register a pulse on each rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist      <= 1'b0;
      r_tickPulse <= 1'b0;
    end else begin
      r_hist      <= w_syncOut;
      r_tickPulse <= w_syncOut & ~r_hist;
    end
  end

  // Compute the time one second ahead, with all carries resolved at once.
  always_comb begin
    w_ssNext = r_ss + 6'd1;
    w_mmNext = r_mm;
    w_hhNext = r_hh;
    if (r_ss == 6'd59) begin
      w_ssNext = 6'd0;
      w_mmNext = r_mm + 6'd1;
      if (r_mm == 6'd59) begin
        w_mmNext = 6'd0;
        w_hhNext = (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
      end
    end
  end

  // Prescaler and time-of-day: any load takes precedence over a tick, and a rejected load changes nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= '0;
      r_hh       <= 5'd0;
      r_mm       <= 6'd0;
      r_ss       <= 6'd0;
      r_secPulse <= 1'b0;
      r_loadErr  <= 1'b0;
    end else begin
      r_secPulse <= 1'b0;
      r_loadErr  <= 1'b0;
      if (load) begin
        if (w_loadValid) begin
          r_hh    <= load_hh;
          r_mm    <= load_mm;
          r_ss    <= load_ss;
          r_presc <= '0;
        end else begin
          r_loadErr <= 1'b1;
        end
      end else if (w_wrap) begin
        r_presc    <= '0;
        r_secPulse <= 1'b1;
        r_hh       <= w_hhNext;
        r_mm       <= w_mmNext;
        r_ss       <= w_ssNext;
      end else if (w_advance) begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Watchdog: count clocks since the last tick, saturating at the stall limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (r_tickPulse) begin
      r_stall <= '0;
    end else if (r_stall != STALL_MAX) begin
      r_stall <= r_stall + SW'(1);
    end
  end

  assign hh         = r_hh;
  assign mm         = r_mm;
  assign ss         = r_ss;
  assign tick_pulse = r_tickPulse;
  assign sec_pulse  = r_secPulse;
  assign load_err   = r_loadErr;
  assign clk_fault  = (r_stall == STALL_MAX);

endmodule

// File: tb/tb_tick_timekeeper.sv
// Directed bench for tick_timekeeper with a 4-tick second and a 50-cycle stall limit.
// All inputs change and all outputs are sampled on the falling clock edge.
module tb_tick_timekeeper;

  localparam int TPS   = 4;
  localparam int STALL = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       run;
  logic       load;
  logic [4:0] load_hh;
  logic [5:0] load_mm;
  logic [5:0] load_ss;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       tick_pulse;
  logic       sec_pulse;
  logic       load_err;
  logic       clk_fault;

  int assertCount = 0;
  int failCount   = 0;
  int nt;
  int ns;

  tick_timekeeper #(
    .SYNC_STAGES  (2),
    .TICKS_PER_SEC(TPS),
    .STALL_CYCLES (STALL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .run       (run),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .tick_pulse(tick_pulse),
    .sec_pulse (sec_pulse),
    .load_err  (load_err),
    .clk_fault (clk_fault)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 200 ns tick_in period, counting tick and second pulses seen during it.
  task automatic applyStimulus(output int nTick, output int nSec);
    nTick = 0;
    nSec  = 0;
    tick_in = 1'b1;
    repeat (10) begin
      @(negedge clk);
      nTick += int'(tick_pulse);
      nSec  += int'(sec_pulse);
    end
    tick_in = 1'b0;
    repeat (10) begin
      @(negedge clk);
      nTick += int'(tick_pulse);
      nSec  += int'(sec_pulse);
    end
  endtask

  task automatic runTicks(input int n, output int nTick, output int nSec);
    int t;
    int s;
    nTick = 0;
    nSec  = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(t, s);
      nTick += t;
      nSec  += s;
    end
  endtask

  task automatic applyLoad(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load_hh = h;
    load_mm = m;
    load_ss = s;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // One tick period with cycle-exact checks of tick_pulse and sec_pulse placement.
  task automatic tickDetailed(input string tag, input logic expSec, input logic [5:0] expSs);
    tick_in = 1'b1;
    nextCycle(1);
    checkOutput({tag, "_tp_n1"}, 32'(tick_pulse), 0);
    nextCycle(1);
    checkOutput({tag, "_tp_n2"}, 32'(tick_pulse), 0);
    nextCycle(1);
    checkOutput({tag, "_tp_n3"}, 32'(tick_pulse), 1);
    checkOutput({tag, "_sp_n3"}, 32'(sec_pulse), 0);
    nextCycle(1);
    checkOutput({tag, "_tp_n4"}, 32'(tick_pulse), 0);
    checkOutput({tag, "_sp_n4"}, 32'(sec_pulse), 32'(expSec));
    checkOutput({tag, "_ss_n4"}, 32'(ss), 32'(expSs));
    nextCycle(1);
    checkOutput({tag, "_sp_n5"}, 32'(sec_pulse), 0);
    nextCycle(5);
    tick_in = 1'b0;
    nextCycle(10);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hh"}, 32'(hh), 0);
    checkOutput({tag, "_mm"}, 32'(mm), 0);
    checkOutput({tag, "_ss"}, 32'(ss), 0);
    checkOutput({tag, "_tick_pulse"}, 32'(tick_pulse), 0);
    checkOutput({tag, "_sec_pulse"}, 32'(sec_pulse), 0);
    checkOutput({tag, "_load_err"}, 32'(load_err), 0);
    checkOutput({tag, "_clk_fault"}, 32'(clk_fault), 0);
  endtask

  // Directed sequence covering counting, rollover, loads, watchdog, run hold and reset.
  initial begin
    rst = 1'b0; tick_in = 1'b0; run = 1'b1; load = 1'b0;
    load_hh = 5'd0; load_mm = 6'd0; load_ss = 6'd0;
    nextCycle(3);
    checkAllZero("reset");
    rst = 1'b1;

    // Basic counting: four ticks make a second.
    tickDetailed("t1_tick1", 1'b0, 6'd0);
    runTicks(2, nt, ns);
    checkOutput("t1_ticks23_sec", 32'(ns), 0);
    tickDetailed("t1_tick4", 1'b1, 6'd1);
    runTicks(4, nt, ns);
    checkOutput("t1_ticks5to8_tick", 32'(nt), 4);
    checkOutput("t1_ticks5to8_sec", 32'(ns), 1);
    checkOutput("t1_ss2", 32'(ss), 2);
    checkOutput("t1_no_fault", 32'(clk_fault), 0);

    // Full-day rollover and hour carry.
    applyLoad(5'd23, 6'd59, 6'd59);
    checkOutput("t2_load_hh", 32'(hh), 23);
    checkOutput("t2_load_mm", 32'(mm), 59);
    checkOutput("t2_load_ss", 32'(ss), 59);
    checkOutput("t2_load_err", 32'(load_err), 0);
    runTicks(4, nt, ns);
    checkOutput("t2_midnight_sec", 32'(ns), 1);
    checkOutput("t2_midnight_hh", 32'(hh), 0);
    checkOutput("t2_midnight_mm", 32'(mm), 0);
    checkOutput("t2_midnight_ss", 32'(ss), 0);
    applyLoad(5'd12, 6'd59, 6'd59);
    runTicks(4, nt, ns);
    checkOutput("t2_13h_hh", 32'(hh), 13);
    checkOutput("t2_13h_mm", 32'(mm), 0);
    checkOutput("t2_13h_ss", 32'(ss), 0);

    // Rejected loads leave time alone and pulse load_err.
    applyLoad(5'd24, 6'd0, 6'd0);
    checkOutput("t3_bad_hh_err", 32'(load_err), 1);
    checkOutput("t3_bad_hh_hh", 32'(hh), 13);
    checkOutput("t3_bad_hh_ss", 32'(ss), 0);
    nextCycle(1);
    checkOutput("t3_bad_hh_err_clear", 32'(load_err), 0);
    applyLoad(5'd10, 6'd60, 6'd0);
    checkOutput("t3_bad_mm_err", 32'(load_err), 1);
    checkOutput("t3_bad_mm_hh", 32'(hh), 13);
    checkOutput("t3_bad_mm_mm", 32'(mm), 0);
    nextCycle(1);
    checkOutput("t3_bad_mm_err_clear", 32'(load_err), 0);
    applyLoad(5'd5, 6'd6, 6'd7);
    checkOutput("t3_good_hh", 32'(hh), 5);
    checkOutput("t3_good_mm", 32'(mm), 6);
    checkOutput("t3_good_ss", 32'(ss), 7);
    checkOutput("t3_good_err", 32'(load_err), 0);

    // Load coinciding with the wrapping tick wins and restarts the prescaler.
    runTicks(3, nt, ns);
    checkOutput("t4_pre3_sec", 32'(ns), 0);
    checkOutput("t4_pre3_ss", 32'(ss), 7);
    tick_in = 1'b1;
    nextCycle(3);
    checkOutput("t4_tp_before_load", 32'(tick_pulse), 1);
    load_hh = 5'd1; load_mm = 6'd2; load_ss = 6'd3; load = 1'b1;
    nextCycle(1);
    load = 1'b0;
    checkOutput("t4_hh", 32'(hh), 1);
    checkOutput("t4_mm", 32'(mm), 2);
    checkOutput("t4_ss", 32'(ss), 3);
    checkOutput("t4_sec_suppressed", 32'(sec_pulse), 0);
    nextCycle(6);
    tick_in = 1'b0;
    nextCycle(10);
    runTicks(3, nt, ns);
    checkOutput("t4_restart3_sec", 32'(ns), 0);
    checkOutput("t4_restart3_ss", 32'(ss), 3);
    runTicks(1, nt, ns);
    checkOutput("t4_restart4_sec", 32'(ns), 1);
    checkOutput("t4_restart4_ss", 32'(ss), 4);

    // Stall watchdog timing, recovery, and run=0 hold.
    tick_in = 1'b1;
    nextCycle(3);
    checkOutput("t5_last_tp", 32'(tick_pulse), 1);
    nextCycle(7);
    tick_in = 1'b0;
    nextCycle(43);
    checkOutput("t5_fault_49", 32'(clk_fault), 0);
    nextCycle(1);
    checkOutput("t5_fault_50", 32'(clk_fault), 1);
    nextCycle(16);
    checkOutput("t5_fault_held", 32'(clk_fault), 1);
    checkOutput("t5_ss_held", 32'(ss), 4);
    tick_in = 1'b1;
    nextCycle(3);
    checkOutput("t5_resume_tp", 32'(tick_pulse), 1);
    checkOutput("t5_fault_before_clear", 32'(clk_fault), 1);
    nextCycle(1);
    checkOutput("t5_fault_cleared", 32'(clk_fault), 0);
    nextCycle(6);
    tick_in = 1'b0;
    nextCycle(10);
    run = 1'b0;
    runTicks(8, nt, ns);
    checkOutput("t5_run0_ticks", 32'(nt), 8);
    checkOutput("t5_run0_sec", 32'(ns), 0);
    checkOutput("t5_run0_ss", 32'(ss), 4);
    run = 1'b1;
    runTicks(1, nt, ns);
    checkOutput("t5_run1_tick3_sec", 32'(ns), 0);
    runTicks(1, nt, ns);
    checkOutput("t5_run1_tick4_sec", 32'(ns), 1);
    checkOutput("t5_run1_ss", 32'(ss), 5);

    // Asynchronous reset mid-count with a fault pending.
    applyLoad(5'd7, 6'd8, 6'd3);
    runTicks(2, nt, ns);
    nextCycle(60);
    checkOutput("t6_pre_fault", 32'(clk_fault), 1);
    checkOutput("t6_pre_ss", 32'(ss), 3);
    checkOutput("t6_pre_hh", 32'(hh), 7);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("t6_async_reset");
    @(negedge clk);
    rst = 1'b1;
    runTicks(3, nt, ns);
    checkOutput("t6_after3_sec", 32'(ns), 0);
    checkOutput("t6_after3_ss", 32'(ss), 0);
    runTicks(1, nt, ns);
    checkOutput("t6_after4_sec", 32'(ns), 1);
    checkOutput("t6_after4_ss", 32'(ss), 1);
    checkOutput("t6_after4_fault", 32'(clk_fault), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
